// File: rtl/controle_porta_pkg.sv
// Shared types and constants for the door controller.
//   estado_t  : FSM state encoding
//   HEX_*     : active-low 7-segment codes (bit 6 = segment g)
//   calc_cw   : timer width able to hold max(a,b)
package controle_porta_pkg;

  typedef enum logic [2:0] {
    FECHADO  = 3'd0,
    ABRINDO  = 3'd1,
    ABERTO   = 3'd2,
    FECHANDO = 3'd3,
    ERRO     = 3'd4
  } estado_t;

  localparam logic [6:0] HEX_F = 7'b0001110;
  localparam logic [6:0] HEX_O = 7'b1000000;
  localparam logic [6:0] HEX_A = 7'b0001000;
  localparam logic [6:0] HEX_E = 7'b0000110;

  function automatic int calc_cw(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

  function automatic logic [6:0] hex_de(input estado_t e);
    case (e)
      FECHADO:           return HEX_F;
      ABRINDO, FECHANDO: return HEX_O;
      ABERTO:            return HEX_A;
      default:           return HEX_E;
    endcase
  endfunction

endpackage

// File: rtl/controle_porta_temporizador.sv
// temporizador_porta: saturating up-counter used by the door FSM.
// Ports:
//   clk_i, rst_i (sync, active-high)
//   clr_i        : force count to 0 (priority over en_i)
//   en_i         : count up by one, holding once limite_i-1 is reached
//   limite_i     : run-time limit chosen by the FSM per state
//   fim_o        : count == limite_i-1
// Parameter LIMITE is the largest limit ever applied; it sizes the counter.
import controle_porta_pkg::*;

module temporizador_porta #(
  parameter int LIMITE = 100
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              clr_i,
  input  logic                              en_i,
  input  logic [calc_cw(LIMITE,LIMITE)-1:0] limite_i,
  output logic                              fim_o
);

  localparam int CW = calc_cw(LIMITE, LIMITE);

  logic [CW-1:0] cont_q, cont_d, ultimo;

  assign ultimo = limite_i - CW'(1);
  assign fim_o  = (cont_q == ultimo);

  always_comb begin
    cont_d = cont_q;
    if (clr_i)
      cont_d = '0;
    else if (en_i && !fim_o)
      cont_d = cont_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cont_q <= '0;
    else       cont_q <= cont_d;
  end

endmodule

// File: rtl/controle_porta.sv
// controle_porta: door motor sequencer with auto-close, LEDs and status code.
// Ports:
//   clock, reset (sync, active-high)
//   botao, trava, sensor_aberta, sensor_fechada, obstaculo : switch inputs
//   motor_abrir, motor_fechar : motor commands
//   ledVerde, ledVermelho     : status LEDs
//   HEX                       : active-low 7-seg code (F/O/A/E)
// Optional macro CONTROLE_PORTA_TIMEOUT_EN adds a motion watchdog (state ERRO).
//
// state    | meaning
// FECHADO  | door closed, waiting for an unlocked open request
// ABRINDO  | open motor running until sensor_aberta
// ABERTO   | door held open, auto-close timer running
// FECHANDO | close motor running; obstacle/button reverses
// ERRO     | motion timeout, left only by reset (watchdog build only)
import controle_porta_pkg::*;

module controle_porta #(
  parameter int T_ABERTA = 50,
  parameter int T_MOTOR  = 100
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       botao,
  input  logic       trava,
  input  logic       sensor_aberta,
  input  logic       sensor_fechada,
  input  logic       obstaculo,
  output logic       motor_abrir,
  output logic       motor_fechar,
  output logic       ledVerde,
  output logic       ledVermelho,
  output logic [6:0] HEX
);

  localparam int LIM_MAX = (T_ABERTA > T_MOTOR) ? T_ABERTA : T_MOTOR;
  localparam int CW      = calc_cw(T_ABERTA, T_MOTOR);
  localparam logic [CW-1:0] LIM_ABERTA = CW'(T_ABERTA);
`ifdef CONTROLE_PORTA_TIMEOUT_EN
  localparam logic [CW-1:0] LIM_MOTOR  = CW'(T_MOTOR);
`endif

  estado_t       estado_q, estado_d;
  logic          fim, tmr_clr, tmr_en;
  logic [CW-1:0] limite;

`ifdef CONTROLE_PORTA_TIMEOUT_EN
  assign limite = (estado_q == ABERTO) ? LIM_ABERTA : LIM_MOTOR;
  assign tmr_en = (estado_q == ABERTO) || (estado_q == ABRINDO) || (estado_q == FECHANDO);
`else
  assign limite = LIM_ABERTA;
  assign tmr_en = (estado_q == ABERTO);
`endif

  // Button in ABERTO restarts the hold time; any state change starts from 0.
  assign tmr_clr = (estado_d != estado_q) || ((estado_q == ABERTO) && botao);

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      FECHADO:  if (botao && !trava) estado_d = ABRINDO;
      ABRINDO: begin
        if (sensor_aberta) estado_d = ABERTO;
`ifdef CONTROLE_PORTA_TIMEOUT_EN
        else if (fim)      estado_d = ERRO;
`endif
      end
      // fim holds while obstaculo is high, so closing follows the obstacle clearing.
      ABERTO:   if (!botao && fim && !obstaculo) estado_d = FECHANDO;
      FECHANDO: begin
        if (obstaculo || botao) estado_d = ABRINDO;
        else if (sensor_fechada) estado_d = FECHADO;
`ifdef CONTROLE_PORTA_TIMEOUT_EN
        else if (fim)            estado_d = ERRO;
`endif
      end
      ERRO:     estado_d = ERRO;
      default:  estado_d = FECHADO;
    endcase
  end

  temporizador_porta #(.LIMITE(LIM_MAX)) u_tmr (
    .clk_i    (clock),
    .rst_i    (reset),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .limite_i (limite),
    .fim_o    (fim)
  );

  // Outputs decoded from the next state so they are valid on state entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q     <= FECHADO;
      motor_abrir  <= 1'b0;
      motor_fechar <= 1'b0;
      ledVerde     <= 1'b0;
      ledVermelho  <= 1'b1;
      HEX          <= HEX_F;
    end else begin
      estado_q     <= estado_d;
      motor_abrir  <= (estado_d == ABRINDO);
      motor_fechar <= (estado_d == FECHANDO);
      ledVerde     <= (estado_d == ABERTO);
      ledVermelho  <= (estado_d != ABERTO);
      HEX          <= hex_de(estado_d);
    end
  end

endmodule

// File: tb/tb_controle_porta.sv
module tb_controle_porta;

  localparam int TA = 5;
  localparam int TM = 8;
`ifdef CONTROLE_PORTA_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  localparam int S_F = 0, S_ABR = 1, S_ABT = 2, S_FCH = 3, S_ERR = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic botao = 1'b0, trava = 1'b0, sensor_aberta = 1'b0, sensor_fechada = 1'b0, obstaculo = 1'b0;
  logic motor_abrir, motor_fechar, ledVerde, ledVermelho;
  logic [6:0] HEX;

  int checks = 0;
  int errors = 0;

  controle_porta #(.T_ABERTA(TA), .T_MOTOR(TM)) dut (
    .clock          (clock),
    .reset          (reset),
    .botao          (botao),
    .trava          (trava),
    .sensor_aberta  (sensor_aberta),
    .sensor_fechada (sensor_fechada),
    .obstaculo      (obstaculo),
    .motor_abrir    (motor_abrir),
    .motor_fechar   (motor_fechar),
    .ledVerde       (ledVerde),
    .ledVermelho    (ledVermelho),
    .HEX            (HEX)
  );

  always #5 clock = ~clock;

  a_motor_excl: assert property (@(posedge clock) !(motor_abrir && motor_fechar));

  // Expected {motor_abrir, motor_fechar, ledVerde, ledVermelho, HEX} per state.
  function automatic logic [10:0] saida(input int s);
    case (s)
      S_F:   return {4'b0001, 7'b0001110};
      S_ABR: return {4'b1001, 7'b1000000};
      S_ABT: return {4'b0010, 7'b0001000};
      S_FCH: return {4'b0101, 7'b1000000};
      default: return {4'b0001, 7'b0000110};
    endcase
  endfunction

  // Reference model: state name plus time spent counting in it.
  int m_st = S_F, m_t = 0, ns = 0, nt = 0;
  bit m_ok = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      m_st = S_F; m_t = 0; m_ok = 1'b1;
    end else if (m_ok) begin
      ns = m_st; nt = m_t;
      case (m_st)
        S_F:   if (botao && !trava) ns = S_ABR;
        S_ABR: begin
          if (sensor_aberta) ns = S_ABT;
          else if (TMO) begin
            if (m_t >= TM - 1) ns = S_ERR; else nt = m_t + 1;
          end
        end
        S_ABT: begin
          if (botao) nt = 0;
          else if (m_t < TA - 1) nt = m_t + 1;
          else if (!obstaculo) ns = S_FCH;
        end
        S_FCH: begin
          if (obstaculo || botao) ns = S_ABR;
          else if (sensor_fechada) ns = S_F;
          else if (TMO) begin
            if (m_t >= TM - 1) ns = S_ERR; else nt = m_t + 1;
          end
        end
        default: ;
      endcase
      if (ns != m_st) nt = 0;
      m_st = ns; m_t = nt;
    end
  end

  always @(negedge clock) begin
    if (m_ok) begin
      checks++;
      if ({motor_abrir, motor_fechar, ledVerde, ledVermelho, HEX} !== saida(m_st)) begin
        errors++;
        $display("FAIL model_cmp t=%0t actual=%b required=%b (model state %0d)", $time,
                 {motor_abrir, motor_fechar, ledVerde, ledVermelho, HEX}, saida(m_st), m_st);
      end
      checks++;
      if (motor_abrir && motor_fechar) begin
        errors++;
        $display("FAIL motor_excl t=%0t actual=both_on required=not_both", $time);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, req);
    end
  endtask

  int n;

  initial begin
    // Reset state
    tick(); reset = 1'b0;
    chk("rst_hex", 32'(HEX), 32'h0E);
    chk("rst_leds", {30'd0, ledVerde, ledVermelho}, 32'd1);
    chk("rst_motors", {30'd0, motor_abrir, motor_fechar}, 32'd0);

    // Open request, then fully open
    botao = 1'b1; tick(); botao = 1'b0;
    chk("abrindo_motor", 32'(motor_abrir), 32'd1);
    chk("abrindo_hex", 32'(HEX), 32'h40);
    sensor_aberta = 1'b1; tick(); sensor_aberta = 1'b0;
    chk("aberto_verde", 32'(ledVerde), 32'd1);
    chk("aberto_hex", 32'(HEX), 32'h08);

    // Auto-close after TA cycles
    n = 0;
    while (!motor_fechar && n < 20) begin tick(); n++; end
    chk("autoclose_cycles", 32'(n), 32'd5);

    // Reversal with obstacle and closed sensor together
    obstaculo = 1'b1; sensor_fechada = 1'b1; tick(); obstaculo = 1'b0; sensor_fechada = 1'b0;
    chk("reversal_motors", {30'd0, motor_abrir, motor_fechar}, 32'd2);

    // Hold-open: button at timer 3 restarts the full hold time
    sensor_aberta = 1'b1; tick(); sensor_aberta = 1'b0;
    repeat (3) tick();
    botao = 1'b1; tick(); botao = 1'b0;
    n = 0;
    while (!motor_fechar && n < 20) begin tick(); n++; end
    chk("holdopen_cycles", 32'(n), 32'd5);

    sensor_fechada = 1'b1; tick(); sensor_fechada = 1'b0;
    chk("fechado_hex", 32'(HEX), 32'h0E);

    // Lock blocks opening
    trava = 1'b1; botao = 1'b1;
    repeat (10) tick();
    chk("lock_motors", {30'd0, motor_abrir, motor_fechar}, 32'd0);
    chk("lock_hex", 32'(HEX), 32'h0E);
    trava = 1'b0; botao = 1'b0;

    // Obstacle held at expiry keeps the door open
    botao = 1'b1; tick(); botao = 1'b0;
    sensor_aberta = 1'b1; tick(); sensor_aberta = 1'b0;
    obstaculo = 1'b1;
    repeat (10) tick();
    chk("obst_hold_verde", 32'(ledVerde), 32'd1);
    obstaculo = 1'b0; tick();
    chk("obst_clear_close", 32'(motor_fechar), 32'd1);

    // Reset mid-ABRINDO
    botao = 1'b1; tick(); botao = 1'b0;
    chk("reabrir_motor", 32'(motor_abrir), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midrst_motor", 32'(motor_abrir), 32'd0);
    chk("midrst_verm", 32'(ledVermelho), 32'd1);
    chk("midrst_hex", 32'(HEX), 32'h0E);

    // Motion watchdog
    botao = 1'b1; tick(); botao = 1'b0;
`ifdef CONTROLE_PORTA_TIMEOUT_EN
    n = 0;
    while (HEX !== 7'b0000110 && n < 30) begin tick(); n++; end
    chk("timeout_cycles", 32'(n), 32'd8);
    chk("erro_motors", {30'd0, motor_abrir, motor_fechar}, 32'd0);
    botao = 1'b1; repeat (3) tick(); botao = 1'b0;
    chk("erro_ignores_botao", 32'(HEX), 32'h06);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("erro_reset_hex", 32'(HEX), 32'h0E);
`else
    repeat (55) tick();
    chk("no_timeout_motor", 32'(motor_abrir), 32'd1);
    chk("no_timeout_hex", 32'(HEX), 32'h40);
    reset = 1'b1; tick(); reset = 1'b0;
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(0, 199) == 0);
      botao          = ($urandom_range(0, 7) == 0);
      trava          = ($urandom_range(0, 3) == 0);
      sensor_aberta  = ($urandom_range(0, 5) == 0);
      sensor_fechada = ($urandom_range(0, 5) == 0);
      obstaculo      = ($urandom_range(0, 4) == 0);
      tick();
    end
    reset = 1'b0; botao = 1'b0; trava = 1'b0;
    sensor_aberta = 1'b0; sensor_fechada = 1'b0; obstaculo = 1'b0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
